// File: rtl/data_bus_responder_if.sv
// data_bus_responder_if: CPU data port plus transmit stream.
// Ports: dataAddress/dataIn/dataWrEn/txReady are driven by the master.
// dataOut/txData/txValid are driven by the slave (the responder).
interface data_bus_responder_if;
    logic [13:0] dataAddress;
    logic [31:0] dataIn;
    logic        dataWrEn;
    logic [31:0] dataOut;
    logic [31:0] txData;
    logic        txValid;
    logic        txReady;
    modport master (output dataAddress, dataIn, dataWrEn, txReady, input dataOut, txData, txValid);
    modport slave  (input dataAddress, dataIn, dataWrEn, txReady, output dataOut, txData, txValid);
endinterface

// File: rtl/data_bus_responder.sv
// data_bus_responder: CPU data-port responder with word RAM and an I/O page (tx FIFO, status, cycle counter).
// Ports: clk rising edge; nRst async active-low; bus (slave) carries
// dataAddress/dataIn/dataWrEn in, dataOut (combinational read) out,
// and the txData/txValid/txReady output stream fed from the FIFO head.
module data_bus_responder #(
    parameter int          RAM_WORDS  = 4096,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [13:0] IO_BASE    = 14'h3FF0
) (
    input logic clk,
    input logic nRst,
    data_bus_responder_if.slave bus
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [13:0] A_TX = IO_BASE;
    localparam logic [13:0] A_ST = IO_BASE + 14'd1;
    localparam logic [13:0] A_CY = IO_BASE + 14'd2;

    logic [31:0] ram  [RAM_WORDS];
    logic [31:0] fifo [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          drop;
    logic [31:0]   cycles;
    logic in_ram, full, empty, wr_tx, wr_st, wr_cy, pop, push, drop_set;
    logic [31:0] status;

    assign in_ram   = {1'b0, bus.dataAddress} < 15'(RAM_WORDS);
    assign full     = count == (PW+1)'(FIFO_DEPTH);
    assign empty    = count == '0;
    assign wr_tx    = bus.dataWrEn && bus.dataAddress == A_TX;
    assign wr_st    = bus.dataWrEn && bus.dataAddress == A_ST;
    assign wr_cy    = bus.dataWrEn && bus.dataAddress == A_CY;
    assign pop      = !empty && bus.txReady;
    // A pop on the same edge frees the slot, so a push into a full FIFO is still taken.
    assign push     = wr_tx && (!full || pop);
    assign drop_set = wr_tx && full && !pop;
    assign status   = {16'h0, 8'(count), 5'h0, drop, empty, full};

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drop   <= 1'b0;
            cycles <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + (PW+1)'(push) - (PW+1)'(pop);
            // Setting wins over a same-edge clear.
            drop   <= drop_set || (drop && !wr_st);
            cycles <= wr_cy ? bus.dataIn : cycles + 32'd1;
        end
    end

    // Storage is not reset.
    always_ff @(posedge clk) begin
        if (bus.dataWrEn && in_ram) ram[bus.dataAddress[AW-1:0]] <= bus.dataIn;
        if (push) fifo[wr_ptr] <= bus.dataIn;
    end

    assign bus.txData  = fifo[rd_ptr];
    assign bus.txValid = !empty;

    always_comb begin
        bus.dataOut = in_ram ? ram[bus.dataAddress[AW-1:0]] :
                      bus.dataAddress == A_ST ? status :
                      bus.dataAddress == A_CY ? cycles : 32'h0;
    end
endmodule

// File: tb/tb_data_bus_responder.sv
// tb_data_bus_responder: scoreboard bench for data_bus_responder.
module tb_data_bus_responder;
    localparam logic [13:0] A_TX = 14'h3FF0;
    localparam logic [13:0] A_ST = 14'h3FF1;
    localparam logic [13:0] A_CY = 14'h3FF2;
    localparam logic [13:0] A_NA = 14'h3FF3;

    logic clk = 1'b0;
    logic nRst = 1'b0;
    logic rd_req = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [31:0] rd_q [$];
    logic [31:0] tx_q [$];

    data_bus_responder_if bus();
    data_bus_responder dut (.clk(clk), .nRst(nRst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        step();
        bus.dataAddress = a;
        bus.dataIn = d;
        bus.dataWrEn = 1'b1;
        rd_req = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        wr(A_TX, d);
        tx_q.push_back(d);
    endtask

    task automatic rd(input logic [13:0] a, input logic [31:0] exp);
        step();
        bus.dataAddress = a;
        bus.dataWrEn = 1'b0;
        rd_q.push_back(exp);
        rd_req = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            bus.dataWrEn = 1'b0;
            rd_req = 1'b0;
        end
    endtask

    // Monitor: compares reads and accepted stream words against queued expectations.
    always @(negedge clk) begin
        if (nRst) begin
            if (rd_req) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 32'h1, 32'h0);
                else chk("rd_data", bus.dataOut, rd_q.pop_front());
            end
            if (bus.txValid && bus.txReady) begin
                if (tx_q.size() == 0) chk("tx_unexpected", bus.txData, 32'hx);
                else chk("tx_data", bus.txData, tx_q.pop_front());
            end
        end
    end

    initial begin
        bus.dataAddress = A_ST;
        bus.dataIn = '0;
        bus.dataWrEn = 1'b0;
        bus.txReady = 1'b0;
        #2;
        chk("rst_status", bus.dataOut, 32'h2);
        chk("rst_txvalid", 32'(bus.txValid), 32'h0);
        bus.dataAddress = A_CY;
        #1;
        chk("rst_cycles", bus.dataOut, 32'h0);
        #9 nRst = 1'b1;
        rd(A_CY, 32'h1);
        // RAM and decode
        wr(14'h0005, 32'hDEADBEEF);
        wr(14'h0FFF, 32'h12345678);
        rd(14'h0005, 32'hDEADBEEF);
        rd(14'h0FFF, 32'h12345678);
        rd(14'h2000, 32'h0);
        rd(A_ST, 32'h2);
        rd(A_TX, 32'h0);
        rd(A_NA, 32'h0);
        // Basic FIFO traffic
        push(32'hA);
        chk("no_fallthrough", 32'(bus.txValid), 32'h0);
        push(32'hB);
        chk("valid_after_push", 32'(bus.txValid), 32'h1);
        push(32'hC);
        rd(A_ST, 32'h300);
        idle(1);
        chk("head_hold1", bus.txData, 32'hA);
        idle(1);
        chk("head_hold2", bus.txData, 32'hA);
        chk("valid_hold", 32'(bus.txValid), 32'h1);
        bus.txReady = 1'b1;
        idle(3);
        bus.txReady = 1'b0;
        rd(A_ST, 32'h2);
        chk("drained_valid", 32'(bus.txValid), 32'h0);
        // Overflow, drop flag, full push-with-pop
        for (int i = 1; i <= 8; i++) push(32'(i));
        wr(A_TX, 32'h9);
        rd(A_ST, 32'h805);
        wr(A_ST, 32'hFFFF_FFFF);
        rd(A_ST, 32'h801);
        push(32'h55);
        bus.txReady = 1'b1;
        rd(A_ST, 32'h801);
        bus.txReady = 1'b0;
        idle(1);
        bus.txReady = 1'b1;
        idle(9);
        bus.txReady = 1'b0;
        rd(A_ST, 32'h2);
        // Cycle counter wrap
        wr(A_CY, 32'hFFFF_FFFE);
        rd(A_CY, 32'hFFFF_FFFE);
        rd(A_CY, 32'hFFFF_FFFF);
        rd(A_CY, 32'h0);
        // Reset mid-drain
        push(32'h31);
        push(32'h32);
        push(32'h33);
        idle(1);
        bus.txReady = 1'b1;
        step();
        bus.dataWrEn = 1'b0;
        rd_req = 1'b0;
        #2 nRst = 1'b0;
        tx_q.delete();
        #1;
        chk("rst_mid_txvalid", 32'(bus.txValid), 32'h0);
        #3 nRst = 1'b1;
        bus.txReady = 1'b0;
        rd(A_ST, 32'h2);
        rd(14'h0005, 32'hDEADBEEF);
        rd(14'h0FFF, 32'h12345678);
        idle(2);
        for (int i = 0; i < 200 && (tx_q.size() != 0 || rd_q.size() != 0); i++) idle(1);
        chk("tx_q_empty", 32'(tx_q.size()), 32'h0);
        chk("rd_q_empty", 32'(rd_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
